token_stream_sender: RTL

- Source endpoint that injects one forward-token stream into a grid link input (the FTk side of a link), and is the transmitter counterpart to the PE fan-in link and ALU consumers.
- Buffers host-written payload words in an internal FIFO and runs the acquire / data / release sequence on the link.
- Honours nack and terminate backward tokens, then reports completion or abort to the host.

---
 rtl/token_stream_sender_if.sv | 39 +++
 rtl/token_stream_sender.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/token_stream_sender_if.sv
// Host and link signal bundle for token_stream_sender.
//   master : the sender side. It takes the host controls, FIFO writes and
//            backward tokens, and drives status and forward tokens.
//   slave  : the host/link side. It drives the opposite directions.
interface token_stream_sender_if #(
  parameter int unsigned WIDTH_DATA   = 32,
  parameter int unsigned WIDTH_LENGTH = 10
);
  logic                    I_Start;
  logic [WIDTH_LENGTH-1:0] I_Length;
  logic                    I_Push;
  logic [WIDTH_DATA-1:0]   I_Data;
  logic                    O_Full;
  logic                    O_Busy;
  logic                    O_Done;
  logic                    O_Abort;
  logic                    O_FTk_v;
  logic                    O_FTk_a;
  logic                    O_FTk_r;
  logic [WIDTH_DATA-1:0]   O_FTk_d;
  logic                    I_BTk_n;
  logic                    I_BTk_t;
  logic                    I_BTk_v;
  logic                    I_BTk_c;

  modport master (
    input  I_Start, I_Length, I_Push, I_Data,
    input  I_BTk_n, I_BTk_t, I_BTk_v, I_BTk_c,
    output O_Full, O_Busy, O_Done, O_Abort,
    output O_FTk_v, O_FTk_a, O_FTk_r, O_FTk_d
  );

  modport slave (
    output I_Start, I_Length, I_Push, I_Data,
    output I_BTk_n, I_BTk_t, I_BTk_v, I_BTk_c,
    input  O_Full, O_Busy, O_Done, O_Abort,
    input  O_FTk_v, O_FTk_a, O_FTk_r, O_FTk_d
  );
endinterface

// File: rtl/token_stream_sender.sv
// Forward-token stream source.
// Buffers host payload words in a FIFO. For each stream it sends an acquire
// token (d = length), waits for the grant, sends the data tokens (the last one
// carries r=1), and then reports done. A terminate flushes the FIFO and
// reports abort.
// Ports:
//   clock, reset : system clock, asynchronous active-low reset.
//   bus          : host controls and status, FIFO write port,
//                  forward token outputs and backward token inputs.
module token_stream_sender #(
  parameter int unsigned WIDTH_DATA   = 32,
  parameter int unsigned WIDTH_LENGTH = 10,
  parameter int unsigned DEPTH_FIFO   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  token_stream_sender_if.master bus
);

  localparam int unsigned WIDTH_PTR = $clog2(DEPTH_FIFO);
  localparam int unsigned WIDTH_CNT = WIDTH_PTR + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_GRANT,
    S_SEND
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH_LENGTH-1:0] rem_q, rem_d;
  logic                    v_q, v_d;
  logic                    a_q, a_d;
  logic                    r_q, r_d;
  logic [WIDTH_DATA-1:0]   d_q, d_d;
  logic                    busy_q;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;

  logic [WIDTH_DATA-1:0]   mem [DEPTH_FIFO];
  logic [WIDTH_PTR-1:0]    wr_q, rd_q;
  logic [WIDTH_CNT-1:0]    count_q;
  logic                    empty, full;
  logic                    pop, flush, push_ok;
  logic [WIDTH_DATA-1:0]   head;

  logic                    accept;
  logic                    unused_btk_c;

  assign unused_btk_c = bus.I_BTk_c;

  assign empty   = (count_q == '0);
  assign full    = (count_q == WIDTH_CNT'(DEPTH_FIFO));
  assign head    = mem[rd_q];
  // A push into a full FIFO is allowed only when a pop frees a slot in the same cycle.
  assign push_ok = bus.I_Push && (!full || pop);
  assign accept  = v_q && !bus.I_BTk_n;

  // Next-state, token register and FIFO control.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    v_d     = v_q;
    a_d     = a_q;
    r_d     = r_q;
    d_d     = d_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.I_Start && (bus.I_Length != '0)) begin
          rem_d   = bus.I_Length;
          v_d     = 1'b1;
          a_d     = 1'b1;
          r_d     = 1'b0;
          d_d     = WIDTH_DATA'(bus.I_Length);
          state_d = S_ACQ;
        end
      end

      S_ACQ: begin
        if (bus.I_BTk_t) begin
          flush   = 1'b1;
        end else if (accept) begin
          v_d     = 1'b0;
          a_d     = 1'b0;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        if (bus.I_BTk_t) begin
          flush   = 1'b1;
        end else if (bus.I_BTk_v) begin
          state_d = S_SEND;
          // Load the first word on the grant edge itself, which saves one cycle.
          if (!empty) begin
            v_d   = 1'b1;
            a_d   = 1'b0;
            r_d   = (rem_q == WIDTH_LENGTH'(1));
            d_d   = head;
            pop   = 1'b1;
            rem_d = rem_q - WIDTH_LENGTH'(1);
          end
        end
      end

      S_SEND: begin
        // Completion wins over a terminate that arrives in the same cycle.
        if (accept && r_q) begin
          v_d     = 1'b0;
          r_d     = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (bus.I_BTk_t) begin
          flush   = 1'b1;
        end else if (!v_q || accept) begin
          if (!empty) begin
            v_d   = 1'b1;
            a_d   = 1'b0;
            r_d   = (rem_q == WIDTH_LENGTH'(1));
            d_d   = head;
            pop   = 1'b1;
            rem_d = rem_q - WIDTH_LENGTH'(1);
          end else begin
            v_d   = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Terminate: clear the token, pulse abort and drop back to idle.
    if (flush) begin
      v_d     = 1'b0;
      a_d     = 1'b0;
      r_d     = 1'b0;
      d_d     = '0;
      abort_d = 1'b1;
      state_d = S_IDLE;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      v_q     <= 1'b0;
      a_q     <= 1'b0;
      r_q     <= 1'b0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      v_q     <= v_d;
      a_q     <= a_d;
      r_q     <= r_d;
      d_q     <= d_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // FIFO pointers and occupancy. A flush discards every queued word, but a
  // push in the same cycle is kept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + WIDTH_PTR'(1);
      end
      if (flush) begin
        rd_q    <= wr_q;
        count_q <= push_ok ? WIDTH_CNT'(1) : '0;
      end else begin
        if (pop) begin
          rd_q <= rd_q + WIDTH_PTR'(1);
        end
        case ({push_ok, pop})
          2'b10:   count_q <= count_q + WIDTH_CNT'(1);
          2'b01:   count_q <= count_q - WIDTH_CNT'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_q] <= bus.I_Data;
    end
  end

  assign bus.O_Full  = full;
  assign bus.O_Busy  = busy_q;
  assign bus.O_Done  = done_q;
  assign bus.O_Abort = abort_q;
  assign bus.O_FTk_v = v_q;
  assign bus.O_FTk_a = a_q;
  assign bus.O_FTk_r = r_q;
  assign bus.O_FTk_d = d_q;

endmodule
